// File: rtl/s2_mem_arbiter.sv
// s2_mem_arbiter: shares the s2 port of the dual-port on-chip RAM between requesters A and B.
// Optional: define S2ARB_PRIO_A_EN for fixed A-priority idle arbitration (default round-robin).
`timescale 1ns/1ps
module s2_mem_arbiter #(
    parameter int unsigned AW        = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          a_req,
    input  logic          a_lock,
    input  logic          a_write,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    input  logic [3:0]    a_be,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    input  logic          b_req,
    input  logic          b_lock,
    input  logic          b_write,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    input  logic [3:0]    b_be,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [31:0]   b_rdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_chipselect,
    output logic          mem_clken,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic [3:0]    mem_byteenable,
    input  logic [31:0]   mem_readdata
);
    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    state_e        state_q;
    logic [7:0]    burst_cnt_q;
    logic          pick_a, pick_b, keep, prefer_b;
    logic          limit_a, limit_b;
    logic          sel_write, sel_lock;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;

    logic [AW-1:0] mem_address_q;
    logic          mem_chipselect_q, mem_clken_q, mem_write_q;
    logic [31:0]   mem_writedata_q;
    logic [3:0]    mem_byteenable_q;
    logic [RD_LAT:0] tag_vld_q, tag_rd_q, tag_b_q;
    logic [31:0]   a_rdata_q, b_rdata_q;

`ifdef S2ARB_PRIO_A_EN
    assign prefer_b = 1'b0;
`else
    logic rr_q;  // 0: A preferred on the next idle tie
    assign prefer_b = rr_q;
`endif

    // The owner yields only once its burst is spent and the other side is actually waiting.
    assign limit_a = (burst_cnt_q >= MaxBurst) && b_req;
    assign limit_b = (burst_cnt_q >= MaxBurst) && a_req;

    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        keep   = 1'b0;
        if (!reset_reset) begin
            unique case (state_q)
                StOwnA: begin
                    if (a_req && !limit_a) begin
                        pick_a = 1'b1;
                        keep   = 1'b1;
                    end else begin
                        pick_b = b_req;
                    end
                end
                StOwnB: begin
                    if (b_req && !limit_b) begin
                        pick_b = 1'b1;
                        keep   = 1'b1;
                    end else begin
                        pick_a = a_req;
                    end
                end
                default: begin
                    if (a_req && b_req) begin
                        pick_a = !prefer_b;
                        pick_b = prefer_b;
                    end else begin
                        pick_a = a_req;
                        pick_b = b_req;
                    end
                end
            endcase
        end
    end

    assign sel_write = pick_a ? a_write : b_write;
    assign sel_lock  = pick_a ? a_lock  : b_lock;
    assign sel_addr  = pick_a ? a_addr  : b_addr;
    assign sel_wdata = pick_a ? a_wdata : b_wdata;
    assign sel_be    = pick_a ? a_be    : b_be;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q          <= StIdle;
            burst_cnt_q      <= '0;
`ifndef S2ARB_PRIO_A_EN
            rr_q             <= 1'b0;
`endif
            mem_address_q    <= '0;
            mem_chipselect_q <= 1'b0;
            mem_clken_q      <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            tag_vld_q        <= '0;
            tag_rd_q         <= '0;
            tag_b_q          <= '0;
            a_rdata_q        <= '0;
            b_rdata_q        <= '0;
        end else begin
            mem_clken_q      <= 1'b1;
            mem_chipselect_q <= pick_a | pick_b;
            mem_write_q      <= (pick_a | pick_b) & sel_write;
            if (pick_a | pick_b) begin
                mem_address_q    <= sel_addr;
                mem_writedata_q  <= sel_wdata;
                mem_byteenable_q <= sel_be;
            end
            tag_vld_q <= {tag_vld_q[RD_LAT-1:0], pick_a | pick_b};
            tag_rd_q  <= {tag_rd_q[RD_LAT-1:0], !sel_write};
            tag_b_q   <= {tag_b_q[RD_LAT-1:0], pick_b};
            if (a_rvalid) a_rdata_q <= mem_readdata;
            if (b_rvalid) b_rdata_q <= mem_readdata;

            if (keep) begin
                if (!sel_lock) begin
                    state_q     <= StIdle;
                    burst_cnt_q <= '0;
                end else if (burst_cnt_q < MaxBurst) begin
                    burst_cnt_q <= burst_cnt_q + 8'd1;
                end
            end else if (pick_a | pick_b) begin
`ifndef S2ARB_PRIO_A_EN
                rr_q <= pick_a;
`endif
                if (sel_lock) begin
                    state_q     <= pick_a ? StOwnA : StOwnB;
                    burst_cnt_q <= 8'd1;
                end else begin
                    state_q     <= StIdle;
                    burst_cnt_q <= '0;
                end
            end else begin
                state_q     <= StIdle;
                burst_cnt_q <= '0;
            end
        end
    end

    assign a_gnt          = pick_a;
    assign b_gnt          = pick_b;
    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_clken      = mem_clken_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;

    assign a_rvalid = tag_vld_q[RD_LAT] & tag_rd_q[RD_LAT] & !tag_b_q[RD_LAT];
    assign b_rvalid = tag_vld_q[RD_LAT] & tag_rd_q[RD_LAT] & tag_b_q[RD_LAT];
    // Data passes straight through in the valid cycle so it lands at T+1+RD_LAT; held afterwards.
    assign a_rdata  = a_rvalid ? mem_readdata : a_rdata_q;
    assign b_rdata  = b_rvalid ? mem_readdata : b_rdata_q;
endmodule

// File: tb/tb_s2_mem_arbiter.sv
// Directed testbench for s2_mem_arbiter: RD_LAT=1 instance with a RAM model, RD_LAT=3 instance
// sharing the same requester inputs for latency and mid-read reset checks.
`timescale 1ns/1ps
module tb_s2_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_lock, a_write, b_req, b_lock, b_write;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_be, b_be;

    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [9:0]  mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [31:0] mem_writedata, mem_readdata;
    logic [3:0]  mem_byteenable;

    logic        c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid;
    logic [31:0] c_a_rdata, c_b_rdata;
    logic [9:0]  c_mem_address;
    logic        c_mem_chipselect, c_mem_clken, c_mem_write;
    logic [31:0] c_mem_writedata;
    logic [3:0]  c_mem_byteenable;
    logic [31:0] c_mem_readdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign c_mem_readdata = 32'hCAFE_F00D;

    s2_mem_arbiter #(.AW(10), .RD_LAT(1), .MAX_BURST(8)) u_dut (
        .clk_clk(clk), .reset_reset(rst),
        .a_req(a_req), .a_lock(a_lock), .a_write(a_write), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_be(a_be), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_write(b_write), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_be(b_be), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata)
    );

    s2_mem_arbiter #(.AW(10), .RD_LAT(3), .MAX_BURST(8)) u_dut3 (
        .clk_clk(clk), .reset_reset(rst),
        .a_req(a_req), .a_lock(a_lock), .a_write(a_write), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_be(a_be), .a_gnt(c_a_gnt), .a_rvalid(c_a_rvalid),
        .a_rdata(c_a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_write(b_write), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_be(b_be), .b_gnt(c_b_gnt), .b_rvalid(c_b_rvalid),
        .b_rdata(c_b_rdata),
        .mem_address(c_mem_address), .mem_chipselect(c_mem_chipselect),
        .mem_clken(c_mem_clken), .mem_write(c_mem_write), .mem_writedata(c_mem_writedata),
        .mem_byteenable(c_mem_byteenable), .mem_readdata(c_mem_readdata)
    );

    // RAM model, read latency 1 from the registered command
    bit          loaded = 1'b0;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    assign mem_readdata = rd_q;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[5] <= 32'hDEAD_BEEF;
            for (int k = 0; k < 3; k++) begin
                mem[32'h20 + k] <= 32'hA000_0000 + k;
                mem[32'h30 + k] <= 32'hB000_0000 + k;
            end
            loaded <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            rd_q <= mem[mem_address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; a_lock = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = 4'hF;
        b_req = 1'b0; b_lock = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = 4'hF;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 1'b1;
        a_addr = 10'h005;
        tick();
        tick();
        sample();
        checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt: a_gnt=%b b_gnt=%b expected 0 0", a_gnt, b_gnt);
        end
        checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0 ||
            mem_address !== 10'h0 || mem_writedata !== 32'h0 || mem_byteenable !== 4'h0) begin
            failures++;
            $display("FAIL reset_mem: cs=%b wr=%b clken=%b addr=%h wd=%h be=%h expected all 0",
                     mem_chipselect, mem_write, mem_clken, mem_address, mem_writedata,
                     mem_byteenable);
        end
        checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0)
        begin
            failures++;
            $display("FAIL reset_rd: a_rvalid=%b b_rvalid=%b a_rdata=%h b_rdata=%h expected 0",
                     a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        tick();
        rst = 1'b0;
        a_req = 1'b0;
        tick();
        sample();
        checks++;
        if (mem_clken !== 1'b1) begin
            failures++;
            $display("FAIL reset_clken: mem_clken=%b expected 1", mem_clken);
        end
    endtask

    task automatic test_single_read();
        tick();
        a_req = 1'b1; a_write = 1'b0; a_addr = 10'h005; a_be = 4'hF;
        sample();
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt: a_gnt=%b b_gnt=%b expected 1 0", a_gnt, b_gnt);
        end
        tick();
        a_req = 1'b0;
        sample();
        checks++;
        if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 10'h005) begin
            failures++;
            $display("FAIL single_cmd: cs=%b wr=%b addr=%h expected 1 0 005",
                     mem_chipselect, mem_write, mem_address);
        end
        tick();
        sample();
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF || b_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_ret: a_rvalid=%b a_rdata=%h b_rvalid=%b expected 1 deadbeef 0",
                     a_rvalid, a_rdata, b_rvalid);
        end
        checks++;
        if (mem_chipselect !== 1'b0 || c_a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_cs_once: cs=%b lat3_rvalid=%b expected 0 0",
                     mem_chipselect, c_a_rvalid);
        end
        tick();
        sample();
        checks++;
        if (a_rvalid !== 1'b0 || c_a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_rvalid_once: a_rvalid=%b lat3_rvalid=%b expected 0 0",
                     a_rvalid, c_a_rvalid);
        end
        tick();
        sample();
        checks++;
        if (c_a_rvalid !== 1'b1 || c_a_rdata !== 32'hCAFE_F00D || c_b_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL lat3_ret: rvalid=%b rdata=%h b_rvalid=%b expected 1 cafef00d 0",
                     c_a_rvalid, c_a_rdata, c_b_rvalid);
        end
    endtask

    task automatic test_write_read(input string tag, input logic [9:0] addr,
                                   input logic [31:0] data, input logic [3:0] be,
                                   input logic [31:0] exp);
        tick();
        b_req = 1'b1; b_write = 1'b1; b_addr = addr; b_wdata = data; b_be = be;
        sample();
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            failures++;
            $display("FAIL %s_wr_gnt: b_gnt=%b a_gnt=%b expected 1 0", tag, b_gnt, a_gnt);
        end
        tick();
        b_write = 1'b0; b_be = 4'hF;
        sample();
        checks++;
        if (b_gnt !== 1'b1 || mem_write !== 1'b1 || mem_chipselect !== 1'b1 ||
            mem_address !== addr || mem_writedata !== data || mem_byteenable !== be) begin
            failures++;
            $display("FAIL %s_wr_cmd: gnt=%b wr=%b cs=%b addr=%h wd=%h be=%h expected 1 1 1 %h %h %h",
                     tag, b_gnt, mem_write, mem_chipselect, mem_address, mem_writedata,
                     mem_byteenable, addr, data, be);
        end
        tick();
        b_req = 1'b0;
        sample();
        checks++;
        if (mem_write !== 1'b0 || mem_chipselect !== 1'b1 || b_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_rd_cmd: wr=%b cs=%b b_rvalid=%b expected 0 1 0",
                     tag, mem_write, mem_chipselect, b_rvalid);
        end
        tick();
        sample();
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== exp || a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_rd_ret: b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1 %h 0",
                     tag, b_rvalid, b_rdata, a_rvalid, exp);
        end
    endtask

    task automatic test_contention();
        int ai = 0;
        int bi = 0;
        logic exp_a, exp_b;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            a_req = (ai < 3); a_write = 1'b0; a_addr = 10'(32'h20 + ai);
            b_req = (bi < 3); b_write = 1'b0; b_addr = 10'(32'h30 + bi);
            sample();
            exp_a = (k < 6) && (k % 2 == 0);
            exp_b = (k < 6) && (k % 2 == 1);
            checks++;
            if (a_gnt !== exp_a || b_gnt !== exp_b) begin
                failures++;
                $display("FAIL rr_gnt[%0d]: a_gnt=%b b_gnt=%b expected %b %b",
                         k, a_gnt, b_gnt, exp_a, exp_b);
            end
            if (a_gnt === 1'b1) ai++;
            if (b_gnt === 1'b1) bi++;
            checks++;
            if (k < 2) begin
                if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_ret[%0d]: a_rvalid=%b b_rvalid=%b expected 0 0",
                             k, a_rvalid, b_rvalid);
                end
            end else if ((k - 2) % 2 == 0) begin
                if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 ||
                    a_rdata !== 32'hA000_0000 + 32'((k - 2) / 2)) begin
                    failures++;
                    $display("FAIL rr_ret[%0d]: a_rvalid=%b b_rvalid=%b a_rdata=%h expected 1 0 %h",
                             k, a_rvalid, b_rvalid, a_rdata, 32'hA000_0000 + 32'((k - 2) / 2));
                end
            end else begin
                if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 ||
                    b_rdata !== 32'hB000_0000 + 32'((k - 2) / 2)) begin
                    failures++;
                    $display("FAIL rr_ret[%0d]: b_rvalid=%b a_rvalid=%b b_rdata=%h expected 1 0 %h",
                             k, b_rvalid, a_rvalid, b_rdata, 32'hB000_0000 + 32'((k - 2) / 2));
                end
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_burst();
        do_reset();
        tick();
        a_req = 1'b1; a_lock = 1'b1; a_write = 1'b0; a_addr = 10'h040;
        b_req = 1'b1; b_write = 1'b0; b_addr = 10'h041;
        for (int k = 0; k < 9; k++) begin
            sample();
            checks++;
            if (a_gnt !== (k < 8) || b_gnt !== (k == 8)) begin
                failures++;
                $display("FAIL burst_limit[%0d]: a_gnt=%b b_gnt=%b expected %b %b",
                         k, a_gnt, b_gnt, k < 8, k == 8);
            end
            tick();
        end
        b_req = 1'b0;
        for (int m = 0; m < 12; m++) begin
            sample();
            checks++;
            if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
                failures++;
                $display("FAIL burst_past_max[%0d]: a_gnt=%b b_gnt=%b expected 1 0",
                         m, a_gnt, b_gnt);
            end
            tick();
        end
        b_req = 1'b1;
        sample();
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            failures++;
            $display("FAIL burst_sat_yield: b_gnt=%b a_gnt=%b expected 1 0", b_gnt, a_gnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        tick();
        a_req = 1'b1; a_write = 1'b0; a_addr = 10'h005;
        sample();
        checks++;
        if (a_gnt !== 1'b1 || c_a_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midrst_gnt: a_gnt=%b lat3_gnt=%b expected 1 1", a_gnt, c_a_gnt);
        end
        tick();
        a_req = 1'b0;
        rst = 1'b1;
        tick();
        sample();
        checks++;
        if (a_rvalid !== 1'b0 || mem_chipselect !== 1'b0 || mem_address !== 10'h0 ||
            mem_clken !== 1'b0 || mem_byteenable !== 4'h0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear: rvalid=%b cs=%b addr=%h clken=%b be=%h wr=%b expected 0",
                     a_rvalid, mem_chipselect, mem_address, mem_clken, mem_byteenable, mem_write);
        end
        checks++;
        if (c_mem_chipselect !== 1'b0 || c_mem_address !== 10'h0 ||
            c_mem_byteenable !== 4'h0) begin
            failures++;
            $display("FAIL midrst_clear3: cs=%b addr=%h be=%h expected 0",
                     c_mem_chipselect, c_mem_address, c_mem_byteenable);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++;
            if (c_a_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_rvalid[%0d]: lat3_rvalid=%b a_rvalid=%b expected 0 0",
                         k, c_a_rvalid, a_rvalid);
            end
            tick();
        end
        a_req = 1'b1; a_addr = 10'h005;
        b_req = 1'b1; b_addr = 10'h005;
        sample();
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || c_a_gnt !== 1'b1 || c_b_gnt !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ptr: a_gnt=%b b_gnt=%b lat3 a=%b b=%b expected 1 0 1 0",
                     a_gnt, b_gnt, c_a_gnt, c_b_gnt);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_read("wr_full", 10'h3FF, 32'h1234_5678, 4'hF, 32'h1234_5678);
        test_write_read("wr_be", 10'h010, 32'hAABB_CCDD, 4'h3, 32'h0000_CCDD);
        test_contention();
        test_burst();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
